div_issue_ctrl: RTL
===================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have ports:
- clk  in  1  clock; all state changes on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX stage holds a divide/remainder op.
- req_mulop  in  mul_ops  op code; only m_div, m_divu, m_rem, m_remu are accepted.
- req_a, req_b  in  32 each  dividend and divisor.
- flush  in  1  EX instruction is squashed this cycle.
- pipeline_stalled  in  1  the pipeline is held by some other hazard.
- req_stall  out  1  stall request to the pipeline.
- resp_valid  out  1  resp_data is valid.
- resp_data  out  32  result to writeback.
- div_start  out  1  start pulse to the iterative divider.
- div_a, div_b  out  32 each  operands to the divider.
- div_mulop  out  mul_ops  op to the divider.
- div_pipeline_stalled  out  1  hold input of the divider.
- div_ready, div_done  in  1 each  divider idle / result-valid.
- div_f  in  32  divider result.

REQ-002 SHALL have no parameters; all widths are fixed at 32.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, DONE.

REQ-004 IDLE with req_valid=1, flush=0 and an accepted op SHALL latch req_a, req_b and req_mulop into op registers.

REQ-005 In the REQ-004 case, a fast-path or cache hit SHALL go to DONE; otherwise it SHALL go to ISSUE.

REQ-006 Fast path, divisor 0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be a, for both signed and unsigned ops.

REQ-007 Fast path, signed overflow (a=0x80000000, b=0xFFFFFFFF, m_div or m_rem): quotient SHALL be 0x80000000 and remainder SHALL be 0.

REQ-008 Cache: one entry {a, b, mulop, result} SHALL be written on every non-flushed completion; an exact match in IDLE SHALL be a hit.

REQ-009 The cache valid bit SHALL clear on reset only.

REQ-010 ISSUE SHALL assert div_start=1 for exactly one cycle, in the first ISSUE cycle that has div_ready=1, and SHALL then go to WAIT.

REQ-011 div_a, div_b and div_mulop SHALL be driven from the op registers and held stable from ISSUE until the cycle after div_done.

REQ-012 WAIT on div_done=1 SHALL capture div_f into the result register and go to DONE; the capture is in the same cycle as div_done.

REQ-013 div_pipeline_stalled SHALL be 0 at all times, so the divider returns to idle the cycle after done.

REQ-014 req_stall SHALL be asserted combinationally in IDLE when req_valid=1 and flush=0, and in ISSUE, WAIT and DRAIN.

REQ-015 req_stall SHALL be 0 in DONE.

REQ-016 resp_valid SHALL be 1 only in DONE, with resp_data equal to the result register.

REQ-017 DONE SHALL stay in DONE while pipeline_stalled=1 and go to IDLE when pipeline_stalled=0.

REQ-018 flush in ISSUE before the start pulse SHALL return to IDLE with no div_start.

REQ-019 flush in WAIT SHALL go to DRAIN; DRAIN SHALL wait for div_done, discard div_f, write no cache entry and return to IDLE.

REQ-020 flush in the same cycle as div_done in WAIT SHALL discard the result and return to IDLE.

REQ-021 flush in DONE SHALL return to IDLE.

REQ-022 An op outside the four accepted codes SHALL be ignored: no stall, and the block stays in IDLE.

REQ-023 Latency: a fast path or cache hit SHALL give exactly 1 stall cycle.

REQ-024 Latency: the divider path SHALL give stall cycles = ISSUE cycles + divider cycles to done + 1 (the IDLE cycle).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, the op and result registers to 0, and the cache valid bit to 0.

REQ-026 While rst_n=0, all outputs SHALL be 0: req_stall, resp_valid, resp_data, div_start, div_a, div_b, div_mulop=m_div encoding 0 and div_pipeline_stalled.

REQ-027 Reset asserted mid-operation SHALL abandon the operation; the divider's own reset is asserted by the same top-level source.

REQ-028 The first edge after rst_n rises SHALL see state IDLE.

Verification
REQ-029 The bench SHALL cover these scenarios:
- m_divu a=100, b=7 -> div_start pulses once; resp_data=14 in DONE; req_stall low from the DONE cycle.
- m_rem a=0xFFFFFF9C (-100), b=7 -> resp_data=0xFFFFFFFE (-2).
- m_div a=0x80000000, b=0xFFFFFFFF -> no div_start; DONE next cycle; resp_data=0x80000000.
- m_remu a=5, b=0 -> no div_start; resp_data=5.
- m_div a=0x80000000, b=0xFFFFFFFF -> no div_start; DONE after 1 stall cycle; resp_data=0x80000000.
- m_divu 100/7 issued twice back-to-back -> the second gets a cache hit, no div_start, resp_data=14.
- flush in WAIT -> DRAIN until div_done; no resp_valid; next op 9/3 gives resp_data=3.
- pipeline_stalled=1 for 3 cycles in DONE -> resp_valid held 3 cycles with stable data.
- rst_n low during WAIT -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue/stall controller between the EX stage and an iterative divider.
// Adds divide-by-zero and signed-overflow fast paths and a 1-entry result cache.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/mulop/a/b   divide/remainder request held by EX
//   flush                 squash of the EX instruction
//   pipeline_stalled      pipeline held by another hazard
//   req_stall             stall request to the pipeline
//   resp_valid/resp_data  result to writeback (valid in DONE only)
//   div_start/a/b/mulop   command to the iterative divider
//   div_pipeline_stalled  divider hold input, tied low
//   div_ready/done/f      divider idle, result valid, result

package div_issue_ctrl_pkg;
    typedef enum logic [2:0] {
        m_div    = 3'd0,
        m_divu   = 3'd1,
        m_rem    = 3'd2,
        m_remu   = 3'd3,
        m_mul    = 3'd4,
        m_mulh   = 3'd5,
        m_mulhsu = 3'd6,
        m_mulhu  = 3'd7
    } mul_ops;
endpackage

module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  mul_ops      req_mulop,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        pipeline_stalled,
    output logic        req_stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output mul_ops      div_mulop,
    output logic        div_pipeline_stalled,
    input  logic        div_ready,
    input  logic        div_done,
    input  logic [31:0] div_f
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] a_q;
    logic [31:0] b_q;
    mul_ops      op_q;
    logic [31:0] res_q;
    logic [31:0] res_d;
    logic        ld_op;
    logic        ld_res;

    logic        c_vld_q;
    logic [31:0] c_a_q;
    logic [31:0] c_b_q;
    mul_ops      c_op_q;
    logic [31:0] c_res_q;
    logic        c_we;
    logic [31:0] c_a_d;
    logic [31:0] c_b_d;
    mul_ops      c_op_d;

    logic        op_ok;
    logic        is_rem;
    logic        is_sgn;
    logic        b_zero;
    logic        ovf;
    logic        fast;
    logic [31:0] fast_res;
    logic        hit;
    logic        accept;
    logic        stall;

    always_comb begin
        op_ok  = 1'b0;
        is_rem = 1'b0;
        is_sgn = 1'b0;
        unique case (req_mulop)
            m_div: begin
                op_ok  = 1'b1;
                is_sgn = 1'b1;
            end
            m_divu: begin
                op_ok  = 1'b1;
            end
            m_rem: begin
                op_ok  = 1'b1;
                is_rem = 1'b1;
                is_sgn = 1'b1;
            end
            m_remu: begin
                op_ok  = 1'b1;
                is_rem = 1'b1;
            end
            default: begin
                op_ok  = 1'b0;
            end
        endcase
    end

    assign accept = req_valid & ~flush & op_ok;
    assign b_zero = (req_b == 32'd0);
    assign ovf    = is_sgn
                  & (req_a == 32'h8000_0000)
                  & (req_b == 32'hFFFF_FFFF);
    assign fast   = b_zero | ovf;

    // Divide by zero wins over overflow; it cannot overlap anyway.
    always_comb begin
        fast_res = 32'd0;
        if (b_zero) begin
            fast_res = is_rem ? req_a : 32'hFFFF_FFFF;
        end else if (ovf) begin
            fast_res = is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    assign hit = c_vld_q
               & (c_a_q == req_a)
               & (c_b_q == req_b)
               & (c_op_q == req_mulop);

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        div_start  = 1'b0;
        ld_op      = 1'b0;
        ld_res     = 1'b0;
        res_d      = div_f;
        c_we       = 1'b0;
        c_a_d      = a_q;
        c_b_d      = b_q;
        c_op_d     = op_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    ld_op = 1'b1;
                    if (fast | hit) begin
                        ld_res  = 1'b1;
                        res_d   = fast ? fast_res : c_res_q;
                        c_we    = 1'b1;
                        c_a_d   = req_a;
                        c_b_d   = req_b;
                        c_op_d  = req_mulop;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (div_ready) begin
                    div_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (div_done) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        ld_res  = 1'b1;
                        c_we    = 1'b1;
                        state_d = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Divider cannot be aborted; let it finish and drop f.
                stall = 1'b1;
                if (div_done) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (flush | ~pipeline_stalled) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= m_div;
            res_q <= 32'd0;
        end else begin
            if (ld_op) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= req_mulop;
            end
            if (ld_res) begin
                res_q <= res_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_q <= 1'b0;
            c_a_q   <= 32'd0;
            c_b_q   <= 32'd0;
            c_op_q  <= m_div;
            c_res_q <= 32'd0;
        end else if (c_we) begin
            c_vld_q <= 1'b1;
            c_a_q   <= c_a_d;
            c_b_q   <= c_b_d;
            c_op_q  <= c_op_d;
            c_res_q <= res_d;
        end
    end

    // IDLE stall is combinational on req_valid; mask it during reset.
    assign req_stall            = stall & rst_n;
    assign resp_data            = res_q;
    assign div_a                = a_q;
    assign div_b                = b_q;
    assign div_mulop            = op_q;
    assign div_pipeline_stalled = 1'b0;

endmodule
